// File: rtl/ifft_core.sv
// ifft_core: fixed 8-point radix-2 DIT inverse FFT, one butterfly per clock.
// Input spectrum is 8.4 fixed point; output time samples are 5.7.
// Optional macro IFFT_SCALE_EN: halve every butterfly result and rescale the
// outputs by 8 at the end. Without it the unscaled working value is passed
// through directly, because an 8.4 sum of eight terms reads as x[n] in 5.7.
module ifft_core (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic signed [11:0] signal_in_frequency_real  [0:7],
  input  logic signed [11:0] signal_in_frequency_image [0:7],
  output logic signed [11:0] signal_out_time_real  [0:7],
  output logic signed [11:0] signal_out_time_image [0:7],
  output logic               BUSY,
  output logic               IFFT_FINISH
);

  localparam int unsigned DW = 12;      // sample width
  localparam int unsigned MW = DW + 9;  // width of x*181 before rounding
  localparam int unsigned PW = 14;      // twiddle product width
  localparam int unsigned SW = 15;      // butterfly sum width
  localparam logic signed [SW-1:0] SAT_HI = SW'(2047);
  localparam logic signed [SW-1:0] SAT_LO = -SW'(2048);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [3:0]           bf_cnt;
  logic signed [DW-1:0] w_re [0:7];
  logic signed [DW-1:0] w_im [0:7];

  logic [2:0]           idx_a, idx_b;
  logic [1:0]           tw;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] p_re, p_im, t_re, t_im;
  logic signed [SW-1:0] s_a_re, s_a_im, s_b_re, s_b_im;
  logic signed [DW-1:0] n_a_re, n_a_im, n_b_re, n_b_im;

  // x * 181/256 with round-half-up
  function automatic logic signed [PW-1:0] mul_c(input logic signed [DW-1:0] x);
    logic signed [MW-1:0] p;
    p = MW'(x) * MW'(181) + MW'(128);
    return PW'(p >>> 8);
  endfunction

  // clamp to the 12-bit signed range
  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      return DW'(SAT_HI);
    else if (v < SAT_LO) return DW'(SAT_LO);
    else                 return DW'(v);
  endfunction

  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // butterfly pair selection, twiddle multiply and saturating add/sub
  always_comb begin
    idx_a = '0;
    idx_b = '0;
    tw    = '0;
    case (bf_cnt[3:2])
      2'd0: begin
        idx_a = {bf_cnt[1:0], 1'b0};
        idx_b = {bf_cnt[1:0], 1'b1};
      end
      2'd1: begin
        idx_a = {bf_cnt[1], 1'b0, bf_cnt[0]};
        idx_b = {bf_cnt[1], 1'b1, bf_cnt[0]};
        tw    = {bf_cnt[0], 1'b0};
      end
      default: begin
        idx_a = {1'b0, bf_cnt[1:0]};
        idx_b = {1'b1, bf_cnt[1:0]};
        tw    = bf_cnt[1:0];
      end
    endcase

    a_re = w_re[idx_a];
    a_im = w_im[idx_a];
    b_re = w_re[idx_b];
    b_im = w_im[idx_b];
    p_re = mul_c(b_re);
    p_im = mul_c(b_im);

    case (tw)
      2'd0: begin t_re = PW'(b_re);   t_im = PW'(b_im); end
      2'd1: begin t_re = p_re - p_im; t_im = p_re + p_im; end
      2'd2: begin t_re = -PW'(b_im);  t_im = PW'(b_re); end
      default: begin t_re = -p_re - p_im; t_im = p_re - p_im; end
    endcase

    s_a_re = SW'(a_re) + SW'(t_re);
    s_a_im = SW'(a_im) + SW'(t_im);
    s_b_re = SW'(a_re) - SW'(t_re);
    s_b_im = SW'(a_im) - SW'(t_im);
`ifdef IFFT_SCALE_EN
    s_a_re = (s_a_re + SW'(1)) >>> 1;
    s_a_im = (s_a_im + SW'(1)) >>> 1;
    s_b_re = (s_b_re + SW'(1)) >>> 1;
    s_b_im = (s_b_im + SW'(1)) >>> 1;
`endif
    n_a_re = sat(s_a_re);
    n_a_im = sat(s_a_im);
    n_b_re = sat(s_b_re);
    n_b_im = sat(s_b_im);
  end

  // control FSM, working registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      bf_cnt      <= '0;
      BUSY        <= 1'b0;
      IFFT_FINISH <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        w_re[i]                  <= '0;
        w_im[i]                  <= '0;
        signal_out_time_real[i]  <= '0;
        signal_out_time_image[i] <= '0;
      end
    end else begin
      IFFT_FINISH <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE) begin
            for (int i = 0; i < 8; i++) begin
              w_re[i] <= signal_in_frequency_real[rev3(3'(i))];
              w_im[i] <= signal_in_frequency_image[rev3(3'(i))];
            end
            bf_cnt <= '0;
            BUSY   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          w_re[idx_a] <= n_a_re;
          w_im[idx_a] <= n_a_im;
          w_re[idx_b] <= n_b_re;
          w_im[idx_b] <= n_b_im;
          if (bf_cnt == 4'd11) state <= DONE;
          else                 bf_cnt <= bf_cnt + 4'd1;
        end
        DONE: begin
          for (int i = 0; i < 8; i++) begin
`ifdef IFFT_SCALE_EN
            signal_out_time_real[i]  <= sat(SW'(w_re[i]) <<< 3);
            signal_out_time_image[i] <= sat(SW'(w_im[i]) <<< 3);
`else
            signal_out_time_real[i]  <= w_re[i];
            signal_out_time_image[i] <= w_im[i];
`endif
          end
          IFFT_FINISH <= 1'b1;
          BUSY        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
